fsm_symbol_tx: RTL and testbench
================================

Name: fsm_symbol_tx

Overview:
- Transmitter for the 2-bit symbol stream consumed by the team's sequence-detector FSM.
- Turns burst commands (class, length, LSB mode) into one symbol per cycle on a valid/ready interface.
- Keeps a shadow copy of the detector state machine, so o_pred_ok gives the detector's output one cycle after each accepted symbol. Benches and upstream logic use it for self-checking.

Parameters:
- LEN_W, 8: width of the burst-length field. Max burst is 2^LEN_W-1 symbols.
- GAP_CYC, 1: idle cycles inserted after a non-empty burst. Legal range 0..15.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_cmd_class  in  1  0 = low class {00,01}; 1 = high class {10,11}
- i_cmd_mode  in  1  0 = constant LSB 0; 1 = LSB alternates 0,1,0,...
- i_cmd_len  in  LEN_W  symbols in the burst (0 = empty burst)
- o_sym_valid  out  1  symbol present
- i_sym_ready  in  1  sink accepts symbol
- o_sym  out  2  symbol value
- o_done  out  1  one-cycle pulse at end of burst
- o_busy  out  1  state != IDLE
- i_sync_clr  in  1  synchronous clear of the shadow detector (detector was reset separately)
- o_pred_ok  out  1  predicted detector output
- o_pred_state  out  3  shadow detector state

Behaviour:
- Reset is asynchronous, active-low on rstn, clock clk.
  - While reset is asserted: state IDLE; o_cmd_ready=0; o_sym_valid=0; o_sym=00; o_done=0; o_busy=0; shadow=INIT; o_pred_ok=0; counters 0.
  - o_cmd_ready rises the first cycle after reset release.
  - Reset mid-burst aborts the burst immediately. No done pulse.
- Transmit FSM has three states: IDLE, SEND, GAP.
  - IDLE: o_cmd_ready=1.
    - On accept with len>0: latch class/mode/len, idx=0, go to SEND. o_sym_valid=1 in the next cycle (1-cycle latency).
    - On accept with len=0: stay IDLE, pulse o_done next cycle, no symbols, no GAP.
  - SEND: o_sym={class, mode ? idx[0] : 0}.
    - o_sym and o_sym_valid are held stable while i_sym_ready=0.
    - On each accept, idx increments.
    - On accept of the symbol with idx==len-1: o_done pulses the next cycle, and the FSM goes to GAP (GAP_CYC>0) or IDLE (GAP_CYC=0).
  - GAP: o_cmd_ready=0, o_sym_valid=0. Stays GAP_CYC cycles, then IDLE.
  - o_cmd_ready=0 in SEND and GAP. Commands offered there wait; they are not dropped.
- Shadow detector states: INIT=0, A0=1, A1=2, OK0=3, OK1=4. Output is 1 in OK0/OK1, else 0. The shadow advances on every symbol accept. Let L = sym in {00,01}.
  - INIT: L -> A0; else -> A1.
  - A0: L -> OK0; else -> A1.
  - A1: L -> A0; else -> OK1.
  - OK0: L -> OK0; 11 -> OK1; 10 -> A1.
  - OK1: 00 -> A0; 01 -> OK0; 1x -> OK1.
  - Illegal encodings -> INIT.
- o_pred_state and o_pred_ok are registered. They update at the same edge that transfers the symbol, so they match the detector's registered output cycle-for-cycle.
- i_sync_clr forces the shadow to INIT.
  - If it is asserted together with a symbol accept, the shadow takes next-state(INIT, sym); the symbol is not lost.
- The shadow persists across bursts and GAP. Only reset or i_sync_clr returns it to INIT.

Decomposition:
- Shared package fsm_pkg holds:
  - detector state encodings (3-bit);
  - class constants CLS_LOW=0, CLS_HIGH=1;
  - symbol constants 00/01/10/11;
  - transmit state enum.
- Sub-module fsm_det_model: purely combinational (cur_state, sym) -> (next_state, ok). It is instantiated here and reused by the detector rewrite.

Test Plan:
- Reset release, cmd class=0 mode=0 len=3, sink ready=1 -> accepted cycle N; o_sym=00 at N+1..N+3; o_pred_ok=0,1,1 at N+2..N+4; o_done at N+4; o_cmd_ready back at N+5 (GAP_CYC=1).
- cmd class=1 mode=1 len=4 from INIT -> o_sym 10,11,10,11; o_pred_state A1,OK1,OK1,OK1.
- Back-to-back cmds L len=2 then H mode=0 len=1 -> 00,00,10; pred_ok 0,1,0 (OK0 on 10 -> A1). Repeat with second cmd mode=1 on a new L/L prefix, so the symbol into OK0 is 10, then extend to len=2 so 11 hits OK1 -> pred_ok 1.
- Backpressure: i_sym_ready low 3 cycles mid-burst -> o_sym/o_sym_valid stable, idx and shadow frozen, no extra symbols.
- len=0 cmd -> o_done pulse next cycle, o_sym_valid never asserted, shadow unchanged. Then i_sync_clr together with an accepted 01 -> shadow = A0.
- rstn low mid-burst (idx=2 of 5) -> all outputs 0 asynchronously, shadow INIT, no o_done; new cmd after release starts cleanly.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared encodings for the 2-bit symbol stream: detector states, symbol classes,
// symbol values and the transmitter FSM states.
package fsm_pkg;

    typedef logic [2:0] det_state_t;
    typedef logic [1:0] tx_state_t;

    localparam det_state_t DET_INIT = 3'd0;
    localparam det_state_t DET_A0   = 3'd1;
    localparam det_state_t DET_A1   = 3'd2;
    localparam det_state_t DET_OK0  = 3'd3;
    localparam det_state_t DET_OK1  = 3'd4;

    localparam logic CLS_LOW  = 1'b0;
    localparam logic CLS_HIGH = 1'b1;

    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;
    localparam logic [1:0] SYM_11 = 2'b11;

    localparam tx_state_t TX_IDLE = 2'd0;
    localparam tx_state_t TX_SEND = 2'd1;
    localparam tx_state_t TX_GAP  = 2'd2;

    function automatic logic det_is_ok(det_state_t s);
        return (s == DET_OK0) || (s == DET_OK1);
    endfunction

endpackage

// File: rtl/fsm_det_model.sv
// Combinational next-state/output function of the sequence detector; o_ok is the
// detector output in the state it moves to.
module fsm_det_model
    import fsm_pkg::*;
(
    input  logic [2:0] i_state,
    input  logic [1:0] i_sym,
    output logic [2:0] o_state,
    output logic       o_ok
);

    logic w_low;

    assign w_low = (i_sym[1] == CLS_LOW);

    always_comb begin
        o_state = DET_INIT;
        case (i_state)
            DET_INIT: o_state = w_low ? DET_A0  : DET_A1;
            DET_A0:   o_state = w_low ? DET_OK0 : DET_A1;
            DET_A1:   o_state = w_low ? DET_A0  : DET_OK1;
            DET_OK0:  o_state = w_low ? DET_OK0 : ((i_sym == SYM_11) ? DET_OK1 : DET_A1);
            DET_OK1:  o_state = w_low ? ((i_sym == SYM_00) ? DET_A0 : DET_OK0) : DET_OK1;
            default:  o_state = DET_INIT;
        endcase
    end

    assign o_ok = det_is_ok(o_state);

endmodule

// File: rtl/fsm_symbol_tx.sv
// Burst symbol transmitter with a shadow copy of the sequence detector, so the
// detector's registered output can be predicted cycle-for-cycle.
module fsm_symbol_tx
    import fsm_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned GAP_CYC = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_class,
    input  logic             i_cmd_mode,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_sym_valid,
    input  logic             i_sym_ready,
    output logic [1:0]       o_sym,
    output logic             o_done,
    output logic             o_busy,
    input  logic             i_sync_clr,
    output logic             o_pred_ok,
    output logic [2:0]       o_pred_state
);

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYC - 1);

    tx_state_t        r_state;
    logic             r_live;
    logic             r_cls;
    logic             r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [3:0]       r_gap;
    logic             r_done;
    det_state_t       r_det;
    logic             r_pred_ok;

    logic       w_cmd_acc;
    logic       w_sym_acc;
    logic       w_last;
    det_state_t w_det_cur;
    det_state_t w_det_nxt;
    logic       w_det_ok;

    // r_live keeps ready low while reset is held and for the release cycle
    assign o_cmd_ready  = r_live && (r_state == TX_IDLE);
    assign o_sym_valid  = (r_state == TX_SEND);
    assign o_sym        = o_sym_valid ? {r_cls, r_mode & r_idx[0]} : SYM_00;
    assign o_busy       = (r_state != TX_IDLE);
    assign o_done       = r_done;
    assign o_pred_state = r_det;
    assign o_pred_ok    = r_pred_ok;

    assign w_cmd_acc = i_cmd_valid && o_cmd_ready;
    assign w_sym_acc = o_sym_valid && i_sym_ready;
    assign w_last    = (r_idx == r_len - LEN_ONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TX_IDLE;
            r_live  <= 1'b0;
            r_cls   <= CLS_LOW;
            r_mode  <= 1'b0;
            r_len   <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (w_cmd_acc) begin
                        if (i_cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cls   <= i_cmd_class;
                            r_mode  <= i_cmd_mode;
                            r_len   <= i_cmd_len;
                            r_idx   <= '0;
                            r_state <= TX_SEND;
                        end
                    end
                end
                TX_SEND: begin
                    if (w_sym_acc) begin
                        r_idx <= r_idx + LEN_ONE;
                        if (w_last) begin
                            r_done <= 1'b1;
                            if (GAP_CYC == 0) begin
                                r_state <= TX_IDLE;
                            end else begin
                                r_state <= TX_GAP;
                                r_gap   <= GAP_LAST;
                            end
                        end
                    end
                end
                TX_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= TX_IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    // A clear coinciding with an accept restarts from INIT but still consumes the symbol
    assign w_det_cur = i_sync_clr ? DET_INIT : r_det;

    fsm_det_model u_det (
        .i_state (w_det_cur),
        .i_sym   (o_sym),
        .o_state (w_det_nxt),
        .o_ok    (w_det_ok)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_det     <= DET_INIT;
            r_pred_ok <= 1'b0;
        end else if (w_sym_acc) begin
            r_det     <= w_det_nxt;
            r_pred_ok <= w_det_ok;
        end else if (i_sync_clr) begin
            r_det     <= DET_INIT;
            r_pred_ok <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsm_symbol_tx.sv
// Bench for fsm_symbol_tx: a queue-based transaction model checked every cycle,
// a vector table of bursts, hand-written corner sequences and a random phase.
module tb_fsm_symbol_tx;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned GAP_CYC = 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_cmd_valid = 1'b0;
    logic             o_cmd_ready;
    logic             i_cmd_class = 1'b0;
    logic             i_cmd_mode = 1'b0;
    logic [LEN_W-1:0] i_cmd_len = '0;
    logic             o_sym_valid;
    logic             i_sym_ready = 1'b1;
    logic [1:0]       o_sym;
    logic             o_done;
    logic             o_busy;
    logic             i_sync_clr = 1'b0;
    logic             o_pred_ok;
    logic [2:0]       o_pred_state;

    always #5 clk = ~clk;

    fsm_symbol_tx #(
        .LEN_W   (LEN_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_class  (i_cmd_class),
        .i_cmd_mode   (i_cmd_mode),
        .i_cmd_len    (i_cmd_len),
        .o_sym_valid  (o_sym_valid),
        .i_sym_ready  (i_sym_ready),
        .o_sym        (o_sym),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .i_sync_clr   (i_sync_clr),
        .o_pred_ok    (o_pred_ok),
        .o_pred_state (o_pred_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Detector transition table [state][symbol]: INIT, A0, A1, OK0, OK1
    int tab [5][4] = '{'{1, 1, 2, 2}, '{3, 3, 2, 2}, '{1, 1, 4, 4},
                       '{3, 3, 2, 4}, '{1, 3, 4, 4}};

    typedef struct packed {
        logic [1:0] sym;
        logic       last;
    } ent_t;

    ent_t       m_q[$];
    int         m_ref = 0;
    int         m_gap = 0;
    bit         m_live = 1'b0;
    bit         m_done_exp = 1'b0;
    bit         m_prev_acc = 1'b0;
    logic [1:0] log_syms[$];
    logic [2:0] log_states[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: expected symbols live in a queue, shadow follows the table
    always @(negedge clk) begin : monitor
        ent_t e;
        bit   rdy;
        if (!rstn) begin
            m_q.delete();
            m_ref      = 0;
            m_gap      = 0;
            m_live     = 1'b0;
            m_done_exp = 1'b0;
            m_prev_acc = 1'b0;
        end else begin
            rdy = m_live && (m_q.size() == 0) && (m_gap == 0);
            check("cmd_ready", int'(o_cmd_ready), int'(rdy));
            check("sym_valid", int'(o_sym_valid), int'(m_q.size() != 0));
            check("sym", int'(o_sym), (m_q.size() != 0) ? int'(m_q[0].sym) : 0);
            check("busy", int'(o_busy), int'((m_q.size() != 0) || (m_gap != 0)));
            check("done", int'(o_done), int'(m_done_exp));
            check("pred_state", int'(o_pred_state), m_ref);
            check("pred_ok", int'(o_pred_ok), int'(m_ref == 3 || m_ref == 4));
            if (m_prev_acc) log_states.push_back(o_pred_state);

            m_live     = 1'b1;
            m_done_exp = 1'b0;
            m_prev_acc = 1'b0;
            if (m_gap > 0) m_gap--;
            if ((m_q.size() != 0) && i_sym_ready) begin
                e = m_q.pop_front();
                log_syms.push_back(e.sym);
                m_prev_acc = 1'b1;
                m_ref = tab[i_sync_clr ? 0 : m_ref][e.sym];
                if (e.last) begin
                    m_done_exp = 1'b1;
                    m_gap      = GAP_CYC;
                end
            end else if (i_sync_clr) begin
                m_ref = 0;
            end
            if (rdy && i_cmd_valid) begin
                if (i_cmd_len == 0) m_done_exp = 1'b1;
                for (int i = 0; i < int'(i_cmd_len); i++) begin
                    e.sym  = 2'(int'(i_cmd_class) * 2 + (i_cmd_mode ? i % 2 : 0));
                    e.last = (i == int'(i_cmd_len) - 1);
                    m_q.push_back(e);
                end
            end
        end
    end

    task automatic send_cmd(input bit c, input bit m, input int len);
        int k;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b1;
        i_cmd_class = c;
        i_cmd_mode  = m;
        i_cmd_len   = LEN_W'(len);
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (o_cmd_ready) break;
        end
        check("cmd_accept_in_time", int'(k < 1000), 1);
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(posedge clk);
            if (m_q.size() == 0 && m_gap == 0 && !m_done_exp && !m_prev_acc) break;
        end
        check("idle_in_time", int'(k < 1000), 1);
    endtask

    task automatic pulse_sync();
        @(posedge clk);
        #1 i_sync_clr = 1'b1;
        @(posedge clk);
        #1 i_sync_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(o_cmd_ready), 0);
        check({tag, "_valid"}, int'(o_sym_valid), 0);
        check({tag, "_sym"}, int'(o_sym), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_pstate"}, int'(o_pred_state), 0);
        check({tag, "_pok"}, int'(o_pred_ok), 0);
    endtask

    // Bursts from INIT; one hex digit per symbol / per post-accept shadow state
    typedef struct {
        int n_cmd;
        bit c0;
        bit m0;
        int l0;
        bit c1;
        bit m1;
        int l1;
        int n;
        int syms;
        int sts;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int took;
        int left;

        vecs[0] = '{1, 0, 0, 3, 0, 0, 0, 3, 'h000, 'h331};
        vecs[1] = '{1, 1, 1, 4, 0, 0, 0, 4, 'h3232, 'h4442};
        vecs[2] = '{1, 0, 1, 4, 0, 0, 0, 4, 'h1010, 'h3331};
        vecs[3] = '{1, 1, 0, 2, 0, 0, 0, 2, 'h22, 'h42};
        vecs[4] = '{2, 0, 0, 2, 1, 0, 1, 3, 'h200, 'h231};
        vecs[5] = '{2, 0, 0, 2, 1, 1, 2, 4, 'h3200, 'h4231};
        vecs[6] = '{2, 1, 1, 3, 0, 1, 2, 5, 'h10232, 'h31442};

        #3;
        check_reset_outputs("rst_hold");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", int'(o_cmd_ready), 0);
        @(negedge clk);
        check("ready_after_release", int'(o_cmd_ready), 1);

        for (int v = 0; v < 7; v++) begin
            pulse_sync();
            log_syms.delete();
            log_states.delete();
            send_cmd(vecs[v].c0, vecs[v].m0, vecs[v].l0);
            if (vecs[v].n_cmd == 2) send_cmd(vecs[v].c1, vecs[v].m1, vecs[v].l1);
            wait_idle();
            check($sformatf("vec%0d_nsym", v), log_syms.size(), vecs[v].n);
            check($sformatf("vec%0d_nstate", v), log_states.size(), vecs[v].n);
            if (log_syms.size() == vecs[v].n && log_states.size() == vecs[v].n) begin
                for (int i = 0; i < vecs[v].n; i++) begin
                    check($sformatf("vec%0d_sym%0d", v, i), int'(log_syms[i]),
                          (vecs[v].syms >> (4 * i)) & 15);
                    check($sformatf("vec%0d_state%0d", v, i), int'(log_states[i]),
                          (vecs[v].sts >> (4 * i)) & 15);
                end
            end
        end

        // Backpressure: stall three cycles while idx 2 is presented
        pulse_sync();
        log_syms.delete();
        log_states.delete();
        send_cmd(1'b0, 1'b1, 5);
        for (int k = 0; k < 50 && log_syms.size() < 2; k++) @(posedge clk);
        #1 i_sym_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_valid", int'(o_sym_valid), 1);
            check("stall_sym", int'(o_sym), 0);
            check("stall_pstate", int'(o_pred_state), 3);
        end
        @(posedge clk);
        #1 i_sym_ready = 1'b1;
        wait_idle();
        check("stall_nsym", log_syms.size(), 5);
        if (log_syms.size() == 5) begin
            check("stall_sym2", int'(log_syms[2]), 0);
            check("stall_sym3", int'(log_syms[3]), 1);
            check("stall_sym4", int'(log_syms[4]), 0);
        end

        // Empty burst: done next cycle, shadow untouched
        send_cmd(1'b1, 1'b0, 0);
        @(negedge clk);
        check("len0_done", int'(o_done), 1);
        check("len0_valid", int'(o_sym_valid), 0);
        check("len0_pstate", int'(o_pred_state), 3);
        @(negedge clk);
        check("len0_done_clear", int'(o_done), 0);

        // Clear together with an accepted 01 lands in A0
        i_sym_ready = 1'b0;
        send_cmd(1'b0, 1'b1, 2);
        @(posedge clk);
        #1 i_sym_ready = 1'b1;
        @(posedge clk);
        #1 i_sync_clr = 1'b1;
        @(negedge clk);
        check("clr_sym", int'(o_sym), 1);
        @(posedge clk);
        #1 i_sync_clr = 1'b0;
        @(negedge clk);
        check("clr_acc_pstate", int'(o_pred_state), 1);
        check("clr_acc_pok", int'(o_pred_ok), 0);
        wait_idle();

        // Longest burst
        pulse_sync();
        log_syms.delete();
        log_states.delete();
        send_cmd(1'b0, 1'b1, 255);
        wait_idle();
        check("max_nsym", log_syms.size(), 255);
        if (log_syms.size() == 255) begin
            check("max_sym253", int'(log_syms[253]), 1);
            check("max_sym254", int'(log_syms[254]), 0);
        end

        // Reset mid-burst at idx 2 of 5
        log_syms.delete();
        log_states.delete();
        send_cmd(1'b0, 1'b0, 5);
        for (int k = 0; k < 50 && log_syms.size() < 2; k++) @(posedge clk);
        #1 rstn = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        check("rst_mid_no_done", int'(o_done), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_no_done_after", int'(o_done), 0);
        log_syms.delete();
        log_states.delete();
        send_cmd(1'b1, 1'b1, 2);
        wait_idle();
        check("post_rst_nsym", log_syms.size(), 2);
        if (log_syms.size() == 2 && log_states.size() == 2) begin
            check("post_rst_sym0", int'(log_syms[0]), 2);
            check("post_rst_sym1", int'(log_syms[1]), 3);
            check("post_rst_state0", int'(log_states[0]), 2);
            check("post_rst_state1", int'(log_states[1]), 4);
        end

        // Random commands, backpressure and clears against the cycle model
        left = 60;
        for (int c = 0; c < 5000 && (left > 0 || i_cmd_valid); c++) begin
            @(negedge clk);
            took = int'(i_cmd_valid && o_cmd_ready);
            @(posedge clk);
            #1;
            if (took != 0) begin
                i_cmd_valid = 1'b0;
                left--;
            end
            if (!i_cmd_valid && left > 0 && $urandom_range(0, 2) == 0) begin
                i_cmd_class = 1'($urandom_range(0, 1));
                i_cmd_mode  = 1'($urandom_range(0, 1));
                i_cmd_len   = LEN_W'($urandom_range(0, 6));
                i_cmd_valid = 1'b1;
            end
            i_sym_ready = ($urandom_range(0, 3) != 0);
            i_sync_clr  = ($urandom_range(0, 15) == 0);
        end
        check("random_cmds_sent", left, 0);
        i_sym_ready = 1'b1;
        i_sync_clr  = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
